// File: rtl/alu_instr_encoder.sv
// Packs an ALUOp code plus register/immediate fields into an RV32 R-type or I-type
// ALU instruction word, buffered through a small FIFO with accept/error counters.
module alu_instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluop,
    input  logic             in_imm_mode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [11:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;
    logic [11:0] imm_field;
    logic [31:0] enc_word;

    always_comb begin
        funct7    = 7'b0000000;
        funct3    = 3'b000;
        legal     = 1'b1;
        imm_field = in_imm;
        case (in_aluop)
            4'b0000: funct3 = 3'b000;
            4'b0001: funct7 = 7'b0100000;
            4'b0010: funct3 = 3'b111;
            4'b0011: funct3 = 3'b110;
            4'b0100: funct3 = 3'b100;
            4'b0101: funct3 = 3'b001;
            4'b0110: funct3 = 3'b101;
            4'b0111: funct3 = 3'b011;
            4'b1000: funct7 = 7'b0000001;
            4'b1001: begin funct7 = 7'b0000001; funct3 = 3'b011; end
            4'b1010: begin funct7 = 7'b0000001; funct3 = 3'b101; end
            4'b1011: begin funct7 = 7'b0000001; funct3 = 3'b111; end
            default: legal = 1'b0;
        endcase
        if (in_imm_mode) begin
            // No I-type form exists for sub or the M-extension ops
            if (in_aluop == 4'b0001 || in_aluop[3]) begin
                legal = 1'b0;
            end
            if (in_aluop == 4'b0101 || in_aluop == 4'b0110) begin
                imm_field = {7'b0, in_imm[4:0]};
                if (in_imm[11:5] != 7'b0) begin
                    legal = 1'b0;
                end
            end
        end
        if (!legal) begin
            enc_word = NOP_WORD;
        end else if (in_imm_mode) begin
            enc_word = {imm_field, in_rs1, funct3, in_rd, 7'b0010011};
        end else begin
            enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
        end
    end

    logic [32:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] enc_q, enc_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             push;
    logic             pop;

    // Ready depends only on registered occupancy, never on out_ready
    assign in_ready  = !rst && (cnt_q < FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        enc_d    = enc_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (enc_q != '1) enc_d = enc_q + 1'b1;
            if (!legal && err_q != '1) err_d = err_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            enc_q    <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            enc_q    <= enc_d;
            err_q    <= err_d;
        end
    end

    // Storage is left unreset; out_valid masks stale contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {!legal, enc_word};
        end
    end

    assign out_instr   = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign out_illegal = out_valid ? mem_q[rd_ptr_q][32] : 1'b0;
    assign enc_count   = enc_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Randomized and directed bench for alu_instr_encoder against a queue-based reference model.
module tb_alu_instr_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_aluop;
    logic             in_imm_mode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [11:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_illegal;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    alu_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_imm_mode(in_imm_mode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: instruction set table by ALUOp, a queue for the buffer, plain counters.
    logic [6:0] f7_tab [12];
    logic [2:0] f3_tab [12];
    logic [32:0] model_q [$];
    int model_enc = 0;
    int model_err = 0;
    bit last_push;

    function automatic logic [32:0] ref_encode(input int op, input bit im, input int rd,
                                               input int rs1, input int rs2, input int imm);
        bit ok;
        int immx;
        logic [31:0] w;
        ok   = (op < 12);
        immx = imm;
        if (im) begin
            if (op == 1 || op >= 8) ok = 0;
            if (op == 5 || op == 6) begin
                if (imm >= 32) ok = 0;
                immx = imm % 32;
            end
        end
        if (!ok) return {1'b1, 32'h13};
        if (im)
            w = (immx << 20) | (rs1 << 15) | (int'(f3_tab[op]) << 12) | (rd << 7) | 32'h13;
        else
            w = (int'(f7_tab[op]) << 25) | (rs2 << 20) | (rs1 << 15) | (int'(f3_tab[op]) << 12)
                | (rd << 7) | 32'h33;
        return {1'b0, w};
    endfunction

    task automatic drive(input int op, input bit im, input int rd, input int rs1,
                         input int rs2, input int imm);
        in_valid    = 1'b1;
        in_aluop    = 4'(op);
        in_imm_mode = im;
        in_rd       = 5'(rd);
        in_rs1      = 5'(rs1);
        in_rs2      = 5'(rs2);
        in_imm      = 12'(imm);
    endtask

    // One clock: compare everything at the negedge, then advance the model at the posedge.
    task automatic step();
        bit do_push, do_pop;
        logic [32:0] e;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!rst && model_q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("out_instr", out_instr, model_q.size() != 0 ? model_q[0][31:0] : 32'h0);
        check("out_illegal", 32'(out_illegal), model_q.size() != 0 ? 32'(model_q[0][32]) : 32'h0);
        check("enc_count", 32'(enc_count), 32'(model_enc));
        check("err_count", 32'(err_count), 32'(model_err));
        do_push = !rst && in_valid && model_q.size() < DEPTH;
        do_pop  = !rst && out_ready && model_q.size() != 0;
        e = ref_encode(int'(in_aluop), in_imm_mode, int'(in_rd), int'(in_rs1),
                       int'(in_rs2), int'(in_imm));
        @(posedge clk);
        last_push = do_push;
        if (rst) begin
            model_q.delete();
            model_enc = 0;
            model_err = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(e);
                if (model_enc < CMAX) model_enc++;
                if (e[32] && model_err < CMAX) model_err++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic directed(input string tag, input int op, input bit im, input int rd,
                            input int rs1, input int rs2, input int imm,
                            input logic [31:0] word, input bit ill);
        drive(op, im, rd, rs1, rs2, imm);
        step();
        in_valid = 1'b0;
        check({tag, "_accept"}, 32'(last_push), 32'd1);
        check({tag, "_word"}, out_instr, word);
        check({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    initial begin
        f7_tab = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                   7'h01, 7'h01, 7'h01, 7'h01};
        f3_tab = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd3,
                   3'd0, 3'd3, 3'd5, 3'd7};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_aluop = '0; in_imm_mode = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        do_reset();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_enc", 32'(enc_count), 32'd0);

        // Known encodings, head visible right after the accepting edge
        directed("add",  4'd0, 1'b0, 3, 1, 2, 0, 32'h002081B3, 1'b0);
        directed("sub",  4'd1, 1'b0, 5, 6, 7, 0, 32'h407302B3, 1'b0);
        directed("mul",  4'd8, 1'b0, 10, 11, 12, 0, 32'h02C58533, 1'b0);
        directed("addi", 4'd0, 1'b1, 1, 0, 0, 12'hFFF, 32'hFFF00093, 1'b0);
        directed("srli", 4'd6, 1'b1, 4, 4, 0, 3, 32'h00325213, 1'b0);

        // Illegal requests
        do_reset();
        directed("subi", 4'd1, 1'b1, 1, 2, 0, 5, 32'h00000013, 1'b1);
        directed("op15", 4'd15, 1'b0, 1, 2, 3, 0, 32'h00000013, 1'b1);
        directed("slli", 4'd5, 1'b1, 1, 2, 0, 12'h020, 32'h00000013, 1'b1);
        step();
        check("illegal_err", 32'(err_count), 32'd3);
        check("illegal_enc", 32'(enc_count), 32'd3);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        drive(0, 1'b0, 3, 1, 2, 0); step();
        drive(8, 1'b0, 10, 11, 12, 0); step();
        drive(1, 1'b0, 5, 6, 7, 0); step();
        check("bp_third_blocked", 32'(last_push), 32'd0);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_head_hold", out_instr, 32'h002081B3);
        out_ready = 1'b1;
        step();
        check("bp_no_push_when_full", 32'(last_push), 32'd0);
        check("bp_second_word", out_instr, 32'h02C58533);
        step();
        check("bp_third_accepted", 32'(last_push), 32'd1);
        in_valid = 1'b0;
        step(); step(); step();

        // Streaming: one entry in flight, no bubbles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive($urandom_range(0, 11), 1'b0, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), 0);
            step();
            check("stream_occ", 32'(model_q.size()), 32'd1);
        end
        in_valid = 1'b0;
        step();

        // Reset with two entries buffered, then a clean request
        out_ready = 1'b0;
        drive(2, 1'b0, 1, 2, 3, 0); step(); step();
        in_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_enc", 32'(enc_count), 32'd0);
        check("rst_mid_err", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        directed("post_rst_add", 4'd0, 1'b0, 3, 1, 2, 0, 32'h002081B3, 1'b0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(15, 1'b0, 1, 1, 1, 0);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check("sat_enc", 32'(enc_count), 32'd15);
        check("sat_err", 32'(err_count), 32'd15);

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int op, imm;
            op  = $urandom_range(0, 15);
            imm = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : $urandom_range(0, 4095);
            drive(op, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), imm);
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            rst       = 1'($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
